result_drain: RTL

RESULT_DRAIN -- requirements
Module: result_drain

---
 rtl/systolic_pkg.sv | 16 +
 rtl/result_drain_if.sv | 30 +++
 rtl/drain_index_counter.sv | 50 +++++
 rtl/result_drain.sv | 91 +++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic result path: drain FSM states and
// the matrix index width.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } drain_state_t;

    // Bits needed to hold a row or column index of a SIZE x SIZE matrix.
    function automatic int idx_w(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/result_drain_if.sv
// Capture/stream bundle between the multiplier array, the result drain and the
// downstream consumer. master = host side, slave = result_drain.
interface result_drain_if #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 4
) ();
    localparam int IW = systolic_pkg::idx_w(SIZE);

    logic                                  start;
    logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]  result_in;
    logic                                  busy;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [WIDTH-1:0]                      out_data;
    logic [IW-1:0]                         out_row;
    logic [IW-1:0]                         out_col;
    logic                                  out_last;
    logic                                  done;

    modport master (
        output start, result_in, out_ready,
        input  busy, out_valid, out_data, out_row, out_col, out_last, done
    );

    modport slave (
        input  start, result_in, out_ready,
        output busy, out_valid, out_data, out_row, out_col, out_last, done
    );

endinterface

// File: rtl/drain_index_counter.sv
// 2-D row/col index counter for the result drain. Row-major by default;
// RESULT_DRAIN_TRANSPOSE_EN switches to column-major walk order.
module drain_index_counter
    import systolic_pkg::*;
#(
    parameter int SIZE = 4,
    localparam int IW  = idx_w(SIZE)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [IW-1:0] row,
    output logic [IW-1:0] col,
    output logic          wrap,
    output logic          last
);
    localparam logic [IW-1:0] MAX = IW'(SIZE - 1);

    assign last = (row == MAX) && (col == MAX);
    // Whole-matrix wrap: the final element is being consumed this cycle.
    assign wrap = enable && last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (enable) begin
`ifdef RESULT_DRAIN_TRANSPOSE_EN
            if (row == MAX) begin
                row <= '0;
                col <= (col == MAX) ? '0 : col + 1'b1;
            end else begin
                row <= row + 1'b1;
            end
`else
            if (col == MAX) begin
                col <= '0;
                row <= (row == MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/result_drain.sv
// Captures a SIZE x SIZE product matrix on start and streams it out one element
// per accepted handshake. Walk order set by RESULT_DRAIN_TRANSPOSE_EN.
module result_drain
    import systolic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SIZE  = 4
) (
    input logic           clock,
    input logic           reset,
    result_drain_if.slave bus
);
    localparam int IW = idx_w(SIZE);

    drain_state_t                          state;
    logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]  buffer;
    logic [IW-1:0]                         row;
    logic [IW-1:0]                         col;
    logic                                  capture;
    logic                                  accept;
    logic                                  wrap;
    logic                                  at_last;

    assign capture = (state == IDLE) && bus.start;
    assign accept  = bus.out_valid && bus.out_ready;

    drain_index_counter #(
        .SIZE (SIZE)
    ) u_index (
        .clock  (clock),
        .reset  (reset),
        .clear  (capture),
        .enable (accept),
        .row    (row),
        .col    (col),
        .wrap   (wrap),
        .last   (at_last)
    );

    // Buffer is loaded only from IDLE, so a drain in flight is never disturbed.
    always_ff @(posedge clock) begin
        if (capture) begin
            buffer <= bus.result_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        state         <= STREAM;
                        bus.busy      <= 1'b1;
                        bus.out_valid <= 1'b1;
                    end
                end
                STREAM: begin
                    if (wrap) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b0;
                        bus.done      <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    bus.busy      <= 1'b0;
                    bus.out_valid <= 1'b0;
                    bus.done      <= 1'b0;
                end
            endcase
        end
    end

    // Data is gated so it reads zero whenever nothing is being presented.
    assign bus.out_data = bus.out_valid ? buffer[row][col] : '0;
    assign bus.out_row  = row;
    assign bus.out_col  = col;
    assign bus.out_last = bus.out_valid && at_last;

endmodule
